// File: rtl/vga_320x240_25m_clk.sv
// 640x480@60 VGA timing generator with pixel coordinates halved to a 320x240 grid.
// Outputs are registered decodes of the next counter values, so they track the counters with no lag.
module vga_320x240_25m_clk #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 1
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       hs,
  output logic       vs,
  output logic [9:0] current_x,
  output logic [9:0] current_y,
  output logic       blank
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;

  // Next counter values and the output decode of those values.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = 10'd0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end else begin
      v_cnt_d = v_cnt_q;
    end

    hs_d    = !((h_cnt_d >= H_SYNC_BEG) && (h_cnt_d < H_SYNC_END));
    vs_d    = !((v_cnt_d >= V_SYNC_BEG) && (v_cnt_d < V_SYNC_END));
    blank_d = (h_cnt_d >= H_VIS_END) || (v_cnt_d >= V_VIS_END);
    x_d     = h_cnt_d >> SCALE_SHIFT;
    y_d     = v_cnt_d >> SCALE_SHIFT;
  end

  // Counters plus flops holding the decode; reset values equal the decode of (0,0).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign hs        = hs_q;
  assign vs        = vs_q;
  assign blank     = blank_q;
  assign current_x = x_q;
  assign current_y = y_q;

endmodule

// File: tb/tb_vga_320x240_25m_clk.sv
// Directed bench: full-size instance for line timing, small instance for frame and mid-frame reset.
module tb_vga_320x240_25m_clk;

  logic       clk;
  logic       resetn_a, resetn_b;
  logic       hs_a, vs_a, blank_a, hs_b, vs_b, blank_b;
  logic [9:0] x_a, y_a, x_b, y_b;

  int total = 0;
  int bad   = 0;

  vga_320x240_25m_clk dut_a (
    .clk(clk), .resetn(resetn_a), .hs(hs_a), .vs(vs_a),
    .current_x(x_a), .current_y(y_a), .blank(blank_a)
  );

  vga_320x240_25m_clk #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_VISIBLE(8), .V_FP(1), .V_SYNC(1), .V_BP(1), .SCALE_SHIFT(1)
  ) dut_b (
    .clk(clk), .resetn(resetn_b), .hs(hs_b), .vs(vs_b),
    .current_x(x_b), .current_y(y_b), .blank(blank_b)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hs_low;
    int vis_cnt;
    int max_x, max_y;
    int hs_fall0, hs_fall1, vs_fall0, vs_fall1;
    int wait_cnt;
    logic hs_prev, vs_prev;

    resetn_a = 1'b1;
    resetn_b = 1'b1;
    #1;
    resetn_a = 1'b0;
    resetn_b = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_hs", {31'd0, hs_a}, 32'd1);
    chk("rst_vs", {31'd0, vs_a}, 32'd1);
    chk("rst_blank", {31'd0, blank_a}, 32'd0);
    chk("rst_x", {22'd0, x_a}, 32'd0);
    chk("rst_y", {22'd0, y_a}, 32'd0);
    chk("rst_b_hs", {31'd0, hs_b}, 32'd1);

    // Full-size instance: walk two lines from reset release.
    resetn_a = 1'b1;
    resetn_b = 1'b1;
    hs_low = 0;
    for (int e = 1; e <= 1600; e++) begin
      @(negedge clk);
      if (e == 1)    chk("x_e1", {22'd0, x_a}, 32'd0);
      if (e == 2)    chk("x_e2", {22'd0, x_a}, 32'd1);
      if (e == 639)  chk("blank_e639", {31'd0, blank_a}, 32'd0);
      if (e == 640)  chk("blank_e640", {31'd0, blank_a}, 32'd1);
      if (e == 655)  chk("hs_e655", {31'd0, hs_a}, 32'd1);
      if (e == 656)  chk("hs_e656", {31'd0, hs_a}, 32'd0);
      if (e == 751)  chk("hs_e751", {31'd0, hs_a}, 32'd0);
      if (e == 752)  chk("hs_e752", {31'd0, hs_a}, 32'd1);
      if (e == 799)  chk("x_e799", {22'd0, x_a}, 32'd399);
      if (e == 799)  chk("y_e799", {22'd0, y_a}, 32'd0);
      if (e == 800)  chk("x_e800", {22'd0, x_a}, 32'd0);
      if (e == 800)  chk("y_e800", {22'd0, y_a}, 32'd0);
      if (e == 800)  chk("blank_e800", {31'd0, blank_a}, 32'd0);
      if (e == 1600) chk("y_e1600", {22'd0, y_a}, 32'd1);
      if (e == 1600) chk("vs_e1600", {31'd0, vs_a}, 32'd1);
      if (e >= 800 && e < 1600 && hs_a == 1'b0) hs_low++;
    end
    chk("hs_low_per_line", hs_low, 32'd96);

    // Small instance: restart it, then scan two frames (24x11 = 264 clocks each).
    @(negedge clk);
    resetn_b = 1'b0;
    @(negedge clk);
    chk("b_rst_blank", {31'd0, blank_b}, 32'd0);
    resetn_b = 1'b1;
    vis_cnt = 0; max_x = 0; max_y = 0;
    hs_fall0 = -1; hs_fall1 = -1; vs_fall0 = -1; vs_fall1 = -1;
    hs_prev = hs_b; vs_prev = vs_b;
    for (int eb = 1; eb <= 528; eb++) begin
      @(negedge clk);
      if (eb == 17) chk("b_hs_17", {31'd0, hs_b}, 32'd1);
      if (eb == 18) chk("b_hs_18", {31'd0, hs_b}, 32'd0);
      if (eb == 21) chk("b_hs_21", {31'd0, hs_b}, 32'd0);
      if (eb == 22) chk("b_hs_22", {31'd0, hs_b}, 32'd1);
      if (eb == 264) chk("b_wrap_blank", {31'd0, blank_b}, 32'd0);
      if (eb == 264) chk("b_wrap_y", {22'd0, y_b}, 32'd0);
      if (eb <= 264 && blank_b == 1'b0) begin
        vis_cnt++;
        if (int'(x_b) > max_x) max_x = int'(x_b);
        if (int'(y_b) > max_y) max_y = int'(y_b);
      end
      if (hs_prev && !hs_b) begin
        if (hs_fall0 < 0) hs_fall0 = eb; else if (hs_fall1 < 0) hs_fall1 = eb;
      end
      if (vs_prev && !vs_b) begin
        if (vs_fall0 < 0) vs_fall0 = eb; else if (vs_fall1 < 0) vs_fall1 = eb;
      end
      hs_prev = hs_b; vs_prev = vs_b;
    end
    chk("b_hs_first_fall", hs_fall0, 32'd18);
    chk("b_line_period", hs_fall1 - hs_fall0, 32'd24);
    chk("b_vs_first_fall", vs_fall0, 32'd216);
    chk("b_frame_period", vs_fall1 - vs_fall0, 32'd264);
    chk("b_visible_count", vis_cnt, 32'd128);
    chk("b_max_x", max_x, 32'd7);
    chk("b_max_y", max_y, 32'd3);

    // Mid-frame reset on the sync line while hs is low (v=9, h=19).
    repeat (235) @(negedge clk);
    chk("b_pre_hs", {31'd0, hs_b}, 32'd0);
    chk("b_pre_vs", {31'd0, vs_b}, 32'd0);
    #5;
    resetn_b = 1'b0;
    #1;
    chk("b_async_hs", {31'd0, hs_b}, 32'd1);
    chk("b_async_vs", {31'd0, vs_b}, 32'd1);
    chk("b_async_y", {22'd0, y_b}, 32'd0);
    @(negedge clk);
    resetn_b = 1'b1;
    wait_cnt = 0;
    while (vs_b == 1'b1 && wait_cnt < 400) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("b_vs_after_reset", wait_cnt, 32'd216);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
